// File: rtl/dcache_wt_if.sv
// dcache_wt_if: groups the pipeline request/response signals and the
// data-memory bus of the write-through data cache into one bundle.
//   slave  : the cache's view (takes pipeline requests, drives the memory bus)
//   master : the environment's view (pipeline plus data memory)
interface dcache_wt_if #(
  parameter int DATA_WIDTH = 32
);
  // Pipeline side
  logic                  req_valid;
  logic                  req_we;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  stall;

  // Data-memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  req_valid, req_we, addr, wdata, funct3, mem_rdata, mem_ready,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_funct3
  );

  modport master (
    output req_valid, req_we, addr, wdata, funct3, mem_rdata, mem_ready,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_funct3
  );
endinterface

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache
// sitting between the MEM-stage load/store path and data memory.
// One 32-bit word per line; loads that hit return in the same cycle,
// load misses fill the line from memory, every store is written through.
// Optional macro DCACHE_STATS_EN adds hit_count / miss_count outputs.
module dcache_wt #(
  parameter int DATA_WIDTH = 32,   // only 32 is supported
  parameter int INDEX_BITS = 8     // log2 of the number of lines
) (
  input  logic        clk,
  input  logic        rst,
  dcache_wt_if.slave  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Storage: valid bits need a reset, tag/data arrays do not.
  // Reads are asynchronous so a load hit costs no extra cycle.
  // ---------------------------------------------------------------------
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [DATA_WIDTH-1:0] r_data [LINES];

  state_t                r_state;
  state_t                w_state_next;

  // Request captured when it is accepted in IDLE; used for the rest of
  // the transaction so the pipeline inputs are never re-sampled.
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_funct3;

  logic                  w_idle;
  logic [31:0]           w_addr;
  logic [2:0]            w_funct3;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [DATA_WIDTH-1:0] w_line_data;
  logic [TAG_BITS-1:0]   w_line_tag;
  logic                  w_line_valid;
  logic                  w_line_match;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merged;

  logic                  w_capture;
  logic                  w_fill_en;
  logic                  w_merge_en;
  logic                  w_stall;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_mem_req;
  logic                  w_mem_we;
  logic [31:0]           w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [2:0]            w_mem_funct3;

  // Select the byte/halfword/word for a load and extend it.
  // addr[0] is ignored for halfwords, the whole offset for words.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b010:  load_extract = word;
      3'b100:  load_extract = {24'h000000, b};
      3'b101:  load_extract = {16'h0000, h};
      default: load_extract = 32'h0000_0000;
    endcase
  endfunction

  // Overlay the stored bytes onto the cached word (store hit update).
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] res;
    res = word;
    case (f3)
      3'b000:  res[{off, 3'b000} +: 8]     = wd[7:0];
      3'b001:  res[{off[1], 4'b0000} +: 16] = wd[15:0];
      3'b010:  res = wd;
      default: res = word;
    endcase
    return res;
  endfunction

  // In IDLE the live pipeline address indexes the array; afterwards the
  // captured one does, so the line lookup follows the accepted request.
  assign w_idle       = (r_state == IDLE);
  assign w_addr       = w_idle ? bus.addr   : r_addr;
  assign w_funct3     = w_idle ? bus.funct3 : r_funct3;
  assign w_index      = w_addr[INDEX_BITS+1:2];
  assign w_tag        = w_addr[31:INDEX_BITS+2];
  assign w_line_data  = r_data[w_index];
  assign w_line_tag   = r_tag[w_index];
  assign w_line_valid = r_valid[w_index];
  assign w_line_match = w_line_valid && (w_line_tag == w_tag);
  assign w_load_data  = load_extract(w_line_data, w_addr[1:0], w_funct3);
  assign w_merged     = store_merge(w_line_data, r_wdata, r_addr[1:0], r_funct3);

  // State register and captured request; reset returns the FSM to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_addr   <= 32'h0000_0000;
      r_wdata  <= '0;
      r_funct3 <= 3'b000;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_we     <= bus.req_we;
        r_addr   <= bus.addr;
        r_wdata  <= bus.wdata;
        r_funct3 <= bus.funct3;
      end
    end
  end

  // Next-state logic and all pipeline/memory outputs.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_fill_en    = 1'b0;
    w_merge_en   = 1'b0;
    w_stall      = 1'b0;
    w_rdata      = '0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = 32'h0000_0000;
    w_mem_wdata  = '0;
    w_mem_funct3 = 3'b000;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_capture = 1'b1;
          if (bus.req_we) begin
            w_stall      = 1'b1;
            w_state_next = WRITE;
          end else if (w_line_match) begin
            w_rdata = w_load_data;
          end else begin
            w_stall      = 1'b1;
            w_state_next = FILL;
          end
        end
      end

      FILL: begin
        w_stall      = 1'b1;
        w_mem_req    = 1'b1;
        w_mem_addr   = {r_addr[31:2], 2'b00};
        w_mem_funct3 = 3'b010;
        if (bus.mem_ready) begin
          w_fill_en    = 1'b1;
          w_state_next = ACK;
        end
      end

      WRITE: begin
        w_stall      = 1'b1;
        w_mem_req    = 1'b1;
        w_mem_we     = 1'b1;
        w_mem_addr   = r_addr;
        w_mem_wdata  = r_wdata;
        w_mem_funct3 = r_funct3;
        if (bus.mem_ready) begin
          // Only an already-present line is updated; misses do not allocate.
          w_merge_en   = w_line_match;
          w_state_next = ACK;
        end
      end

      ACK: begin
        if (!r_we) begin
          w_rdata = w_load_data;
        end
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    // While reset is held the pipeline must see no stall and no data,
    // even with a request present.
    if (rst) begin
      w_stall = 1'b0;
      w_rdata = '0;
    end
  end

  assign bus.stall      = w_stall;
  assign bus.rdata      = w_rdata;
  assign bus.mem_req    = w_mem_req;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.mem_funct3 = w_mem_funct3;

  // Valid bits: cleared by reset, set when a fill completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_fill_en) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  // Tag/data arrays: written by a completed fill or a store hit.
  always_ff @(posedge clk) begin
    if (w_fill_en) begin
      r_data[w_index] <= bus.mem_rdata;
      r_tag[w_index]  <= w_tag;
    end else if (w_merge_en) begin
      r_data[w_index] <= w_merged;
    end
  end

`ifdef DCACHE_STATS_EN
  // Load hit / load miss counters; stores are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 32'h0000_0000;
      miss_count <= 32'h0000_0000;
    end else begin
      if (w_idle && bus.req_valid && !bus.req_we && w_line_match) begin
        hit_count <= hit_count + 32'd1;
      end
      if (w_idle && (w_state_next == FILL)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
